// File: rtl/rv32_pkg.sv
// Shared RV32 core types: data-memory request/response bundles
// and small helpers used by the memory-side arbitration logic.
package rv32_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic {
      PRIO_FIXED = 1'b0,
      PRIO_RR    = 1'b1
   } prio_mode_e;

   typedef struct packed {
      logic            valid;
      logic            we;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } rv32_dmem_req_t;

   typedef struct packed {
      logic            rvalid;
      logic [XLEN-1:0] rdata;
   } rv32_dmem_rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way one-hot grant: lone requester wins; on contention the one
// that did not win last wins, unless force1 hands it to requester 1.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       force1,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (force1 || !last_grant) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory port arbiter (pipeline MEM stage vs debug/DMA)
// with single-cycle load response routing and requester-1 starvation guard.
module dmem_arbiter
   import rv32_pkg::*;
#(
   parameter int PRIO_MODE    = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic        req0_we,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   output logic        req0_ready,
   output logic [31:0] req0_rdata,
   output logic        req0_rvalid,
   input  logic        req1_valid,
   input  logic        req1_we,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic        req1_ready,
   output logic [31:0] req1_rdata,
   output logic        req1_rvalid,
   output logic        mem_we,
   output logic        mem_re,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   // STARVE_LIMIT must be at least 1
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   rv32_dmem_req_t req0, req1, win;
   rv32_dmem_rsp_t rsp0, rsp1;

   logic [1:0]    req_v, gnt;
   logic          xfer, force1, arb_last;
   logic          last_q, last_d;
   logic          pend_q, pend_d;
   logic          owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d;

   assign req0 = '{valid: req0_valid, we: req0_we,
                   addr: req0_addr, wdata: req0_wdata};
   assign req1 = '{valid: req1_valid, we: req1_we,
                   addr: req1_addr, wdata: req1_wdata};

   // Reset masks both requests so no grant can leak out.
   assign req_v    = reset ? 2'b00 : {req1.valid, req0.valid};
   assign force1   = (PRIO_MODE == int'(PRIO_FIXED)) &&
                     (cnt_q >= CW'(STARVE_LIMIT));
   assign arb_last = (PRIO_MODE == int'(PRIO_FIXED)) ? 1'b1 : last_q;

   rr_arb2 u_arb (
      .req        (req_v),
      .last_grant (arb_last),
      .force1     (force1),
      .gnt        (gnt)
   );

   always_comb begin
      xfer       = |gnt;
      win        = gnt[1] ? req1 : req0;
      req0_ready = gnt[0];
      req1_ready = gnt[1];
      mem_we     = xfer & win.we;
      mem_re     = xfer & ~win.we;
      mem_addr   = xfer ? win.addr : '0;
      mem_wdata  = xfer ? win.wdata : '0;
   end

   always_comb begin
      rsp0.rvalid = pend_q & ~reset & ~owner_q;
      rsp1.rvalid = pend_q & ~reset & owner_q;
      rsp0.rdata  = rsp0.rvalid ? mem_rdata : '0;
      rsp1.rdata  = rsp1.rvalid ? mem_rdata : '0;
      req0_rvalid = rsp0.rvalid;
      req0_rdata  = rsp0.rdata;
      req1_rvalid = rsp1.rvalid;
      req1_rdata  = rsp1.rdata;
   end

   always_comb begin
      last_d  = xfer ? gnt[1] : last_q;
      pend_d  = mem_re;
      owner_d = mem_re ? gnt[1] : owner_q;
      cnt_d   = cnt_q;
      if (!req1.valid || gnt[1])
         cnt_d = '0;
      else if (gnt[0] && (cnt_q < CW'(STARVE_LIMIT)))
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q  <= 1'b1;
         pend_q  <= 1'b0;
         owner_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         last_q  <= last_d;
         pend_q  <= pend_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

   // A stalled requester must keep its request stable until accepted.
   a_hold0 : assert property (@(posedge clk) disable iff (reset)
      req0_valid && !req0_ready |=> req0_valid && $stable(req0_we) &&
      $stable(req0_addr) && $stable(req0_wdata));

   a_hold1 : assert property (@(posedge clk) disable iff (reset)
      req1_valid && !req1_ready |=> req1_valid && $stable(req1_we) &&
      $stable(req1_addr) && $stable(req1_wdata));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance
// run side by side against a behavioural arbitration model.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        iv  [2][2];
   logic        iwe [2][2];
   logic [31:0] ia  [2][2];
   logic [31:0] id  [2][2];
   logic        ordy[2][2];
   logic        orv [2][2];
   logic [31:0] ord [2][2];
   logic        mwe [2];
   logic        mre [2];
   logic [31:0] maddr[2];
   logic [31:0] mwd  [2];
   logic [31:0] mrd  [2];
   logic [31:0] tmem [2][64];

   int n_cmp = 0;
   int n_bad = 0;

   int          last_g[2];
   int          streak[2];
   int          owner [2];
   int          won   [2];
   bit          pend  [2];
   logic [31:0] pdata [2];
   logic [31:0] rmem  [2][64];
   logic        obs_r0[2];
   logic        obs_r1[2];
   logic        obs_rv0[2];
   logic [31:0] obs_rd0[2];
   logic        seq[10];

   dmem_arbiter u_rr (
      .clk(clk), .reset(rst),
      .req0_valid(iv[0][0]), .req0_we(iwe[0][0]),
      .req0_addr(ia[0][0]), .req0_wdata(id[0][0]),
      .req0_ready(ordy[0][0]), .req0_rdata(ord[0][0]),
      .req0_rvalid(orv[0][0]),
      .req1_valid(iv[0][1]), .req1_we(iwe[0][1]),
      .req1_addr(ia[0][1]), .req1_wdata(id[0][1]),
      .req1_ready(ordy[0][1]), .req1_rdata(ord[0][1]),
      .req1_rvalid(orv[0][1]),
      .mem_we(mwe[0]), .mem_re(mre[0]),
      .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
      .mem_rdata(mrd[0])
   );

   dmem_arbiter #(.PRIO_MODE(0), .STARVE_LIMIT(4)) u_fp (
      .clk(clk), .reset(rst),
      .req0_valid(iv[1][0]), .req0_we(iwe[1][0]),
      .req0_addr(ia[1][0]), .req0_wdata(id[1][0]),
      .req0_ready(ordy[1][0]), .req0_rdata(ord[1][0]),
      .req0_rvalid(orv[1][0]),
      .req1_valid(iv[1][1]), .req1_we(iwe[1][1]),
      .req1_addr(ia[1][1]), .req1_wdata(id[1][1]),
      .req1_ready(ordy[1][1]), .req1_rdata(ord[1][1]),
      .req1_rvalid(orv[1][1]),
      .mem_we(mwe[1]), .mem_re(mre[1]),
      .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
      .mem_rdata(mrd[1])
   );

   for (genvar k = 0; k < 2; k++) begin : g_mem
      always @(posedge clk) begin
         if (mre[k]) mrd[k] <= tmem[k][maddr[k][7:2]];
         if (mwe[k]) tmem[k][maddr[k][7:2]] = mwd[k];
      end
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set(int k, int n, logic v, logic we,
                      logic [31:0] a, logic [31:0] d);
      iv[k][n]  = v;
      iwe[k][n] = we;
      ia[k][n]  = a;
      id[k][n]  = d;
   endtask

   task automatic idle();
      for (int k = 0; k < 2; k++)
         for (int n = 0; n < 2; n++)
            set(k, n, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Evaluate one cycle: check outputs against the model, then advance it.
   task automatic cycle();
      #2;
      for (int k = 0; k < 2; k++) begin
         int          w;
         bit          ld, st, erv0, erv1;
         logic [31:0] ea, ed;
         string       p;
         p = (k == 0) ? "rr" : "fp";
         w = -1;
         if (!rst) begin
            if (iv[k][0] && iv[k][1]) begin
               if (k == 0) w = (last_g[k] == 0) ? 1 : 0;
               else        w = (streak[k] >= 4) ? 1 : 0;
            end else if (iv[k][0]) w = 0;
            else if (iv[k][1])     w = 1;
         end
         ld   = (w >= 0) && !iwe[k][w];
         st   = (w >= 0) && iwe[k][w];
         ea   = (w >= 0) ? ia[k][w] : 32'h0;
         ed   = (w >= 0) ? id[k][w] : 32'h0;
         erv0 = !rst && pend[k] && (owner[k] == 0);
         erv1 = !rst && pend[k] && (owner[k] == 1);
         chk({p, ".ready0"}, 32'(ordy[k][0]), 32'(w == 0));
         chk({p, ".ready1"}, 32'(ordy[k][1]), 32'(w == 1));
         chk({p, ".mem_re"}, 32'(mre[k]), 32'(ld));
         chk({p, ".mem_we"}, 32'(mwe[k]), 32'(st));
         chk({p, ".mem_addr"}, maddr[k], ea);
         chk({p, ".mem_wdata"}, mwd[k], ed);
         chk({p, ".rvalid0"}, 32'(orv[k][0]), 32'(erv0));
         chk({p, ".rvalid1"}, 32'(orv[k][1]), 32'(erv1));
         chk({p, ".rdata0"}, ord[k][0], erv0 ? pdata[k] : 32'h0);
         chk({p, ".rdata1"}, ord[k][1], erv1 ? pdata[k] : 32'h0);
         obs_r0[k]  = ordy[k][0];
         obs_r1[k]  = ordy[k][1];
         obs_rv0[k] = orv[k][0];
         obs_rd0[k] = ord[k][0];
         won[k]     = w;
         if (rst) begin
            last_g[k] = 1;
            streak[k] = 0;
            pend[k]   = 1'b0;
            owner[k]  = 0;
         end else begin
            pend[k] = ld;
            if (ld) begin
               owner[k] = w;
               pdata[k] = rmem[k][ea[7:2]];
            end
            if (st) rmem[k][ea[7:2]] = ed;
            if (w >= 0) last_g[k] = w;
            if (!iv[k][1] || w == 1) streak[k] = 0;
            else if (w == 0)         streak[k]++;
         end
      end
      @(negedge clk);
   endtask

   // Retire accepted requests until every held one has been granted.
   task automatic drain();
      repeat (4) begin
         for (int k = 0; k < 2; k++)
            for (int n = 0; n < 2; n++)
               if (won[k] == n) iv[k][n] = 1'b0;
         cycle();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic rnd_inputs();
      for (int k = 0; k < 2; k++)
         for (int n = 0; n < 2; n++)
            if (!(iv[k][n] && won[k] != n))
               set(k, n, ($urandom % 4) != 0, $urandom % 2,
                   {24'h0, 6'($urandom % 64), 2'b00}, $urandom);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      for (int k = 0; k < 2; k++) begin
         won[k] = -1;
         last_g[k] = 1;
         streak[k] = 0;
         owner[k] = 0;
         pend[k] = 1'b0;
         pdata[k] = 32'h0;
         for (int i = 0; i < 64; i++) begin
            logic [31:0] v;
            v = $urandom;
            tmem[k][i] = v;
            rmem[k][i] = v;
         end
         tmem[k][4] = 32'hDEADBEEF;
         rmem[k][4] = 32'hDEADBEEF;
      end
      @(negedge clk);

      // valid during reset: nothing granted, everything quiet
      set(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
      set(0, 1, 1'b1, 1'b1, 32'h8, 32'h55);
      set(1, 0, 1'b1, 1'b0, 32'h10, 32'h0);
      cycle();
      cycle();
      rst = 1'b0;
      idle();

      // single load of 0x10
      set(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
      cycle();
      chk("single.ready_T", 32'(obs_r0[0]), 32'h1);
      idle();
      cycle();
      chk("single.rdata_T1", obs_rd0[0], 32'hDEADBEEF);

      // round-robin contention from reset
      do_reset();
      set(0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
      set(0, 1, 1'b1, 1'b0, 32'h4, 32'h0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         seq[i] = obs_r1[0];
      end
      for (int i = 0; i < 4; i++)
         chk("rr.grant_order", 32'(seq[i]), 32'(i % 2));
      drain();

      // fixed priority with starvation guard
      set(1, 0, 1'b1, 1'b0, 32'h0, 32'h0);
      set(1, 1, 1'b1, 1'b0, 32'h4, 32'h0);
      for (int i = 0; i < 10; i++) begin
         cycle();
         seq[i] = obs_r1[1];
      end
      for (int i = 0; i < 10; i++)
         chk("fp.grant_order", 32'(seq[i]), 32'(i % 5 == 4));
      drain();

      // store then load same address
      set(0, 1, 1'b1, 1'b1, 32'h20, 32'h12345678);
      cycle();
      idle();
      set(0, 0, 1'b1, 1'b0, 32'h20, 32'h0);
      cycle();
      idle();
      cycle();
      chk("st_ld.rvalid", 32'(obs_rv0[0]), 32'h1);
      chk("st_ld.rdata", obs_rd0[0], 32'h12345678);

      // reset in the middle of a load
      set(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
      cycle();
      idle();
      rst = 1'b1;
      cycle();
      chk("rst_mid.rvalid_T1", 32'(obs_rv0[0]), 32'h0);
      rst = 1'b0;
      cycle();
      chk("rst_mid.rvalid_T2", 32'(obs_rv0[0]), 32'h0);
      set(0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
      set(0, 1, 1'b1, 1'b0, 32'h4, 32'h0);
      cycle();
      chk("rst_mid.first_grant", 32'(obs_r0[0]), 32'h1);
      drain();

      // randomized traffic with occasional resets
      repeat (400) begin
         rst = (($urandom % 40) == 0);
         rnd_inputs();
         cycle();
      end
      rst = 1'b0;
      drain();
      idle();
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter PRIO_MODE, default 1, meaning 0 = fixed priority to requester 0, 1 = round-robin.
REQ-002 Parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive requester-0 grants while requester 1 waits (PRIO_MODE=0 only).
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqN_valid  input  1  requester N (N=0 pipeline memory stage, N=1 debug/DMA) presents a request.
REQ-006 reqN_we  input  1  1 = store, 0 = load.
REQ-007 reqN_addr  input  32  byte address.
REQ-008 reqN_wdata  input  32  store data, already width-formatted by the requester.
REQ-009 reqN_ready  output  1  the request is accepted this cycle.
REQ-010 reqN_rdata  output  32  load data.
REQ-011 reqN_rvalid  output  1  reqN_rdata is valid this cycle.
REQ-012 mem_we, mem_re  output  1 each  the write and read enables to the data memory.
REQ-013 mem_addr, mem_wdata  output  32 each  the shared read/write address and the write data.
REQ-014 mem_rdata  input  32  memory read data, valid one cycle after mem_re.

Function
REQ-015 The block SHALL issue at most one memory access per cycle; a transfer occurs when reqN_valid && reqN_ready.
REQ-016 The ready signal SHALL be combinational: it is asserted only to the winner of the current cycle, and only when that requester's valid is high.
REQ-017 When only one requester is valid, that requester SHALL win.
REQ-018 Round-robin (PRIO_MODE=1): when both are valid, the requester that did not win the last grant SHALL win; last_grant updates only on a transfer.
REQ-019 Fixed priority (PRIO_MODE=0): when both are valid, requester 0 SHALL win until the starvation counter reaches STARVE_LIMIT.
REQ-020 Starvation counter: it increments on each requester-0 grant while req1_valid is high, the next contended cycle then grants requester 1, and the counter clears on any requester-1 grant or when req1_valid is low.
REQ-021 On a transfer, mem_we/mem_re, mem_addr and mem_wdata SHALL be driven combinationally from the winner in the same cycle; with no transfer, mem_we=mem_re=0 and address/data are don't-care, held at 0.
REQ-022 Load response: a one-bit pending register and an owner register are set at an issued load; in the next cycle, owner rvalid=1 and rdata=mem_rdata.
REQ-023 The non-owner's rvalid SHALL be 0 and its rdata 0.
REQ-024 Back-to-back loads SHALL be accepted every cycle (full throughput, no bubble), with responses in issue order at latency 1.
REQ-025 A store SHALL produce no rvalid.
REQ-026 A store followed by a load to the same address in the next cycle SHALL return the new data (ordering is preserved by the single port).
REQ-027 A requester SHALL hold valid, we, addr and wdata stable until ready; the block does not check this, and an assertion flags violations.
REQ-028 Simultaneous valid and reset: reset SHALL take precedence, and no grant is issued.

Reset
REQ-029 While reset=1: all ready signals, rvalid signals, mem_we and mem_re SHALL be 0, and all rdata outputs 0.
REQ-030 Reset state: pending=0, owner=0, last_grant=1 (so requester 0 wins the first contention), starvation counter=0.
REQ-031 Reset mid-operation: an in-flight load response SHALL be dropped, with no rvalid in the cycle after reset deasserts.

Structure
REQ-032 The shared package rv32_pkg SHALL gain rv32_dmem_req_t {valid, we, addr, wdata} and rv32_dmem_rsp_t {rvalid, rdata}.
REQ-033 The width constant for STARVE_LIMIT SHALL be $clog2(STARVE_LIMIT+1).
REQ-034 The two-way grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], last_grant, force1; output one-hot gnt[1:0]); the response tracking and the counter stay in dmem_arbiter.

Verification
REQ-035 Single load: req0 load addr 0x10 (memory holds 0xDEADBEEF) -> req0_ready at cycle T, mem_re=1 at T, req0_rvalid=1 with rdata 0xDEADBEEF at T+1, req1_rvalid=0.
REQ-036 Round-robin contention: both valid for 4 cycles, loads to 0x0/0x4 -> grants 0,1,0,1, rvalid alternating owners one cycle later.
REQ-037 Fixed-priority starvation: PRIO_MODE=0, STARVE_LIMIT=4, both continuously valid -> grant pattern 0,0,0,0,1 repeating.
REQ-038 Store-then-load: req1 stores 0x12345678 to 0x20 at T, req0 loads 0x20 at T+1 -> req0_rdata=0x12345678 at T+2.
REQ-039 Reset mid-load: load issued at T, reset=1 at T+1 -> rvalid=0 at T+1 and T+2, and after release the first contention grants requester 0.
